// File: rtl/barcode_pkg.sv
// Shared definitions for the barcode link (transmitter and receiver):
// FSM state type and the low-pulse fractions of each cell type.
package barcode_pkg;

  typedef enum logic [1:0] {StIdle, StStart, StData} bc_state_e;

  // Low portion of a cell as num/den of the bit period
  localparam int unsigned StartLowNum = 1;
  localparam int unsigned StartLowDen = 2;
  localparam int unsigned Bit1LowNum  = 1;
  localparam int unsigned Bit1LowDen  = 4;
  localparam int unsigned Bit0LowNum  = 3;
  localparam int unsigned Bit0LowDen  = 4;

  function automatic int unsigned bc_low_clocks(input int unsigned period,
                                                input int unsigned num,
                                                input int unsigned den);
    return period * num / den;
  endfunction

endpackage

// File: rtl/bc_cell_timer.sv
// Bit-cell timer: free-runs 0..BIT_PERIOD-1 while not cleared and flags the
// low/high transition points and the cell boundary.
module bc_cell_timer
  import barcode_pkg::*;
#(
  parameter int unsigned BIT_PERIOD = 512
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  output logic o_quarter,
  output logic o_half,
  output logic o_three_quarter,
  output logic o_cell_end
);

  localparam int unsigned CntW = $clog2(BIT_PERIOD);
  localparam logic [CntW-1:0] LastCnt    = CntW'(BIT_PERIOD - 1);
  localparam logic [CntW-1:0] QuarterCnt =
      CntW'(bc_low_clocks(BIT_PERIOD, Bit1LowNum, Bit1LowDen));
  localparam logic [CntW-1:0] HalfCnt    =
      CntW'(bc_low_clocks(BIT_PERIOD, StartLowNum, StartLowDen));
  localparam logic [CntW-1:0] ThreeQCnt  =
      CntW'(bc_low_clocks(BIT_PERIOD, Bit0LowNum, Bit0LowDen));

  logic [CntW-1:0] r_cnt;
  logic            r_cell_end;

  // cell_end is registered so it never fires on the very first count of a frame
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_cnt      <= '0;
      r_cell_end <= 1'b0;
    end else begin
      r_cell_end <= (r_cnt == LastCnt);
      r_cnt      <= (r_cnt == LastCnt) ? '0 : r_cnt + 1'b1;
    end
  end

  assign o_quarter       = (r_cnt == QuarterCnt);
  assign o_half          = (r_cnt == HalfCnt);
  assign o_three_quarter = (r_cnt == ThreeQCnt);
  assign o_cell_end      = r_cell_end;

endmodule

// File: rtl/barcode_tx.sv
// Barcode line transmitter: start cell plus 8 pulse-width data cells, MSB first.
// Define BC_ID_CHECK_EN to reject IDs with ID[7:6] != 2'b00 (pulses id_err).
module barcode_tx
  import barcode_pkg::*;
#(
  parameter int unsigned BIT_PERIOD = 512
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       send,
  input  logic [7:0] ID,
  output logic       BC,
  output logic       busy,
  output logic       done,
  output logic       id_err
);

  bc_state_e  r_state, w_state_nx;
  logic [7:0] r_sh, w_sh_nx;
  logic [2:0] r_bit, w_bit_nx;
  logic       r_bc, w_bc_nx;
  logic       r_busy, w_busy_nx;
  logic       r_done, w_done_nx;
  logic       r_id_err, w_id_err_nx;

  logic w_quarter, w_half, w_three_q, w_cell_end;
  logic w_id_ok, w_last_cell, w_timer_clr;

`ifdef BC_ID_CHECK_EN
  assign w_id_ok = (ID[7:6] == 2'b00);
`else
  assign w_id_ok = 1'b1;
`endif

  assign w_last_cell = (r_state == StData) && w_cell_end && (r_bit == 3'd0);
  // Restart the cell timer on a chained request accepted at the frame-end edge
  assign w_timer_clr = (r_state == StIdle) || w_last_cell;

  bc_cell_timer #(
    .BIT_PERIOD(BIT_PERIOD)
  ) u_timer (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_clear        (w_timer_clr),
    .o_quarter      (w_quarter),
    .o_half         (w_half),
    .o_three_quarter(w_three_q),
    .o_cell_end     (w_cell_end)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= StIdle;
      r_sh     <= '0;
      r_bit    <= '0;
      r_bc     <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_id_err <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_sh     <= w_sh_nx;
      r_bit    <= w_bit_nx;
      r_bc     <= w_bc_nx;
      r_busy   <= w_busy_nx;
      r_done   <= w_done_nx;
      r_id_err <= w_id_err_nx;
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_sh_nx     = r_sh;
    w_bit_nx    = r_bit;
    w_bc_nx     = r_bc;
    w_busy_nx   = r_busy;
    w_done_nx   = 1'b0;
    w_id_err_nx = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (send) begin
          if (w_id_ok) begin
            w_state_nx = StStart;
            w_sh_nx    = ID;
            w_bit_nx   = 3'd7;
          end else begin
            w_id_err_nx = 1'b1;
          end
        end
      end
      StStart: begin
        // First cycle in START (busy still low) drives the frame's first falling edge
        if (!r_busy) begin
          w_bc_nx   = 1'b0;
          w_busy_nx = 1'b1;
        end else if (w_cell_end) begin
          w_state_nx = StData;
          w_bc_nx    = 1'b0;
        end else if (w_half) begin
          w_bc_nx = 1'b1;
        end
      end
      StData: begin
        if (w_cell_end) begin
          if (r_bit == 3'd0) begin
            w_bc_nx    = 1'b1;
            w_busy_nx  = 1'b0;
            w_done_nx  = 1'b1;
            w_state_nx = StIdle;
            if (send) begin
              if (w_id_ok) begin
                w_state_nx = StStart;
                w_sh_nx    = ID;
                w_bit_nx   = 3'd7;
              end else begin
                w_id_err_nx = 1'b1;
              end
            end
          end else begin
            w_bit_nx = r_bit - 3'd1;
            w_bc_nx  = 1'b0;
          end
        end else if (r_sh[r_bit] ? w_quarter : w_three_q) begin
          w_bc_nx = 1'b1;
        end
      end
      default: w_state_nx = StIdle;
    endcase
  end

  assign BC     = r_bc;
  assign busy   = r_busy;
  assign done   = r_done;
  assign id_err = r_id_err;

endmodule

// File: tb/tb_barcode_tx.sv
// Directed bench for barcode_tx at BIT_PERIOD=16; line activity is captured per
// scenario and compared against hand-derived edge times and pulse widths.
module tb_barcode_tx;

  localparam int unsigned BP = 16;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic       send = 1'b0;
  logic [7:0] id   = 8'h00;
  logic       bc, busy, done, id_err;

  int total = 0;
  int bad   = 0;
  int edge_cnt = 0;

  int fall_t [32];
  int low_w  [32];
  int done_t [4];
  int n_fall, n_done, busy_cnt, err_cnt, low_cnt;
  int snap_bc, snap_busy;

  barcode_tx #(
    .BIT_PERIOD(BP)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .send  (send),
    .ID    (id),
    .BC    (bc),
    .busy  (busy),
    .done  (done),
    .id_err(id_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Record line activity for ncyc edges; optionally pulse send or rst at given edges
  task automatic capture(input int ncyc, input int on_at, input int off_at,
                         input logic [7:0] on_id, input int rst_at);
    logic prev;
    n_fall = 0; n_done = 0; busy_cnt = 0; err_cnt = 0; low_cnt = 0;
    snap_bc = -1; snap_busy = -1;
    prev = bc;
    for (int i = 0; i < ncyc; i++) begin
      step();
      if (edge_cnt == on_at) begin
        send = 1'b1;
        id   = on_id;
      end
      if (edge_cnt == off_at) send = 1'b0;
      rst = (edge_cnt == rst_at);
      if (edge_cnt == rst_at + 1) begin
        snap_bc   = int'(bc);
        snap_busy = int'(busy);
      end
      if (prev && !bc && n_fall < 32) begin
        fall_t[n_fall] = edge_cnt;
        low_w[n_fall]  = -1;
        n_fall++;
      end
      if (!prev && bc && n_fall > 0) low_w[n_fall-1] = edge_cnt - fall_t[n_fall-1];
      if (done) begin
        if (n_done < 4) done_t[n_done] = edge_cnt;
        n_done++;
      end
      busy_cnt += int'(busy);
      err_cnt  += int'(id_err);
      low_cnt  += int'(!bc);
      prev = bc;
    end
  endtask

  task automatic accept(input logic [7:0] v, output int n);
    id   = v;
    send = 1'b1;
    step();
    n    = edge_cnt;
    send = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    total++; if (bc !== 1'b1)     begin bad++; $display("FAIL reset_bc got=%b exp=1", bc); end
    total++; if (busy !== 1'b0)   begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0)   begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (id_err !== 1'b0) begin bad++; $display("FAIL reset_id_err got=%b exp=0", id_err); end
    rst = 1'b0;
    capture(50, -1, -1, 8'h00, -1);
    total++; if (low_cnt !== 0)  begin bad++; $display("FAIL idle_bc_low got=%0d exp=0", low_cnt); end
    total++; if (busy_cnt !== 0) begin bad++; $display("FAIL idle_busy got=%0d exp=0", busy_cnt); end
  endtask

  task automatic test_frame_25();
    int n;
    logic [7:0] v;
    v = 8'h25;
    accept(v, n);
    capture(160, -1, -1, 8'h00, -1);
    total++; if (n_fall !== 9) begin bad++; $display("FAIL f25_nfall got=%0d exp=9", n_fall); end
    for (int k = 0; k < 9 && k < n_fall; k++) begin
      total++;
      if (fall_t[k] !== n + 1 + 16 * k) begin
        bad++; $display("FAIL f25_fall%0d got=%0d exp=%0d", k, fall_t[k], n + 1 + 16 * k);
      end
      total++;
      if (low_w[k] !== ((k == 0) ? 8 : (v[8-k] ? 4 : 12))) begin
        bad++; $display("FAIL f25_width%0d got=%0d exp=%0d", k, low_w[k],
                        (k == 0) ? 8 : (v[8-k] ? 4 : 12));
      end
    end
    total++; if (n_done !== 1) begin bad++; $display("FAIL f25_ndone got=%0d exp=1", n_done); end
    total++;
    if (n_done < 1 || done_t[0] !== n + 145) begin
      bad++; $display("FAIL f25_done_time got=%0d exp=%0d", (n_done > 0) ? done_t[0] : -1, n + 145);
    end
    total++; if (busy_cnt !== 144) begin bad++; $display("FAIL f25_busy got=%0d exp=144", busy_cnt); end
  endtask

  task automatic test_ignored_send();
    int n;
    logic [7:0] v;
    v = 8'h25;
    accept(v, n);
    capture(220, n + 39, n + 40, 8'h3F, -1);
    total++; if (n_fall !== 9) begin bad++; $display("FAIL ign_nfall got=%0d exp=9", n_fall); end
    for (int k = 1; k < 9 && k < n_fall; k++) begin
      total++;
      if (low_w[k] !== (v[8-k] ? 4 : 12)) begin
        bad++; $display("FAIL ign_width%0d got=%0d exp=%0d", k, low_w[k], v[8-k] ? 4 : 12);
      end
    end
    total++; if (n_done !== 1) begin bad++; $display("FAIL ign_ndone got=%0d exp=1", n_done); end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [15:0] v;
    v = 16'h003F;
    accept(8'h00, n);
    send = 1'b1;
    id   = 8'h3F;
    capture(300, -1, n + 145, 8'h00, -1);
    total++; if (n_fall !== 18) begin bad++; $display("FAIL b2b_nfall got=%0d exp=18", n_fall); end
    total++;
    if (n_fall < 10 || fall_t[9] !== n + 146) begin
      bad++; $display("FAIL b2b_second_fall got=%0d exp=%0d", (n_fall > 9) ? fall_t[9] : -1, n + 146);
    end
    for (int k = 0; k < 18 && k < n_fall; k++) begin
      total++;
      if (low_w[k] !== ((k % 9 == 0) ? 8 : (v[(k < 9) ? 16 - k : 17 - k] ? 4 : 12))) begin
        bad++; $display("FAIL b2b_width%0d got=%0d exp=%0d", k, low_w[k],
                        (k % 9 == 0) ? 8 : (v[(k < 9) ? 16 - k : 17 - k] ? 4 : 12));
      end
    end
    total++; if (n_done !== 2) begin bad++; $display("FAIL b2b_ndone got=%0d exp=2", n_done); end
    total++; if (busy_cnt !== 288) begin bad++; $display("FAIL b2b_busy got=%0d exp=288", busy_cnt); end
  endtask

  task automatic test_mid_reset();
    int n;
    logic [7:0] v;
    accept(8'h25, n);
    capture(120, -1, -1, 8'h00, n + 70);
    total++; if (snap_bc !== 1)   begin bad++; $display("FAIL rst_bc got=%0d exp=1", snap_bc); end
    total++; if (snap_busy !== 0) begin bad++; $display("FAIL rst_busy got=%0d exp=0", snap_busy); end
    total++; if (n_done !== 0)    begin bad++; $display("FAIL rst_done got=%0d exp=0", n_done); end
    v = 8'h5A;
    accept(v, n);
    capture(160, -1, -1, 8'h00, -1);
    total++; if (n_fall !== 9) begin bad++; $display("FAIL rst_nfall got=%0d exp=9", n_fall); end
    for (int k = 1; k < 9 && k < n_fall; k++) begin
      total++;
      if (low_w[k] !== (v[8-k] ? 4 : 12)) begin
        bad++; $display("FAIL rst_width%0d got=%0d exp=%0d", k, low_w[k], v[8-k] ? 4 : 12);
      end
    end
    total++; if (n_done !== 1) begin bad++; $display("FAIL rst_ndone got=%0d exp=1", n_done); end
  endtask

  task automatic test_id_check();
    int n;
    logic [7:0] v;
`ifdef BC_ID_CHECK_EN
    accept(8'hC1, n);
    total++; if (id_err !== 1'b1) begin bad++; $display("FAIL chk_err got=%b exp=1", id_err); end
    capture(40, -1, -1, 8'h00, -1);
    total++; if (err_cnt !== 0)  begin bad++; $display("FAIL chk_err_len got=%0d exp=0", err_cnt); end
    total++; if (n_fall !== 0)   begin bad++; $display("FAIL chk_nfall got=%0d exp=0", n_fall); end
    total++; if (busy_cnt !== 0) begin bad++; $display("FAIL chk_busy got=%0d exp=0", busy_cnt); end
    v = 8'h01;
`else
    v = 8'hC1;
`endif
    accept(v, n);
    total++; if (id_err !== 1'b0) begin bad++; $display("FAIL chk_ok_err got=%b exp=0", id_err); end
    capture(160, -1, -1, 8'h00, -1);
    total++; if (n_fall !== 9) begin bad++; $display("FAIL chk_ok_nfall got=%0d exp=9", n_fall); end
    for (int k = 1; k < 9 && k < n_fall; k++) begin
      total++;
      if (low_w[k] !== (v[8-k] ? 4 : 12)) begin
        bad++; $display("FAIL chk_ok_width%0d got=%0d exp=%0d", k, low_w[k], v[8-k] ? 4 : 12);
      end
    end
    total++; if (err_cnt !== 0) begin bad++; $display("FAIL chk_ok_errcnt got=%0d exp=0", err_cnt); end
    total++; if (n_done !== 1)  begin bad++; $display("FAIL chk_ok_ndone got=%0d exp=1", n_done); end
  endtask

  initial begin
    test_reset();
    test_frame_25();
    test_ignored_send();
    test_back_to_back();
    test_mid_reset();
    test_id_check();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
